// File: rtl/alpha_ramp_pkg.sv
// Shared definitions for the alpha ramp controller: key bit positions,
// the per-key repeat FSM state encoding and a counter width helper.
package alpha_ramp_pkg;

    localparam int KEY_DN   = 0;
    localparam int KEY_UP   = 1;
    localparam int KEY_MODE = 2;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Bits needed for a down-counter that is loaded with at most max(a,b)-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/alpha_key_repeat.sv
// One key channel: level register, press edge detect and hold/auto-repeat
// FSM driven by a single down-counter; emits one-cycle step pulses.
//
// state      | meaning
// -----------+--------------------------------------------------------
// RPT_IDLE   | key released, or held without a qualifying press
// RPT_HOLD   | pressed, counting REPEAT_DLY held cycles before repeat
// RPT_REPEAT | auto-repeat, one step every REPEAT_PER held cycles
module alpha_key_repeat
    import alpha_ramp_pkg::*;
#(
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    input  logic clr,
    output logic press,
    output logic held,
    output logic step
);
    localparam int CNT_W = cnt_width(REPEAT_DLY, REPEAT_PER);

    logic             key_q;
    logic             key_qd;
    logic             armed;
    rpt_state_e       state;
    rpt_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // armed only sets once a released level is seen, so a key held through
    // reset cannot produce a press when reset lifts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q  <= 1'b1;
            key_qd <= 1'b1;
            armed  <= 1'b0;
            state  <= RPT_IDLE;
            cnt    <= '0;
        end else begin
            key_q  <= key_n;
            key_qd <= key_q;
            armed  <= armed | key_n;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
        end
    end

    assign held  = ~key_q;
    assign press = armed & key_qd & ~key_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step      = 1'b0;
        if (clr || !held) begin
            state_nxt = RPT_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RPT_IDLE: begin
                    if (press) begin
                        step      = 1'b1;
                        state_nxt = RPT_HOLD;
                        cnt_nxt   = CNT_W'(REPEAT_DLY - 1);
                    end
                end
                RPT_HOLD, RPT_REPEAT: begin
                    if (cnt == '0) begin
                        step      = 1'b1;
                        state_nxt = RPT_REPEAT;
                        cnt_nxt   = CNT_W'(REPEAT_PER - 1);
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = RPT_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alpha_ramp_ctrl.sv
// Alpha blend coefficient ramp: saturating up/down keys with auto-repeat.
// Define ALPHA_RAMP_FADE_EN to build in the mode key and triangle auto-fade.
module alpha_ramp_ctrl
    import alpha_ramp_pkg::*;
#(
    parameter int ALPHA_W    = 9,
    parameter int ALPHA_MAX  = 256,
    parameter int ALPHA_INIT = 127,
    parameter int STEP       = 1,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 2_500_000,
    parameter int FADE_DIV   = 195_312
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         key_n,
    output logic [ALPHA_W-1:0] alpha_data,
    output logic [ALPHA_W-1:0] alpha_inv,
    output logic               alpha_vld,
    output logic               fade_on
);
    localparam int                 W1     = ALPHA_W + 1;
    localparam logic [W1-1:0]      MAX_W  = W1'(ALPHA_MAX);
    localparam logic [W1-1:0]      STEP_W = W1'(STEP);
    localparam logic [ALPHA_W-1:0] MAX_A  = ALPHA_W'(ALPHA_MAX);

    logic               press_up, press_dn;
    logic               held_up, held_dn;
    logic               step_up, step_dn;
    logic               both_held;
    logic               do_up, do_dn;
    logic [ALPHA_W-1:0] alpha_nxt;

    // One extra bit so overflow past ALPHA_MAX and borrow below 0 are visible.
    function automatic logic [ALPHA_W-1:0] sat_up(input logic [ALPHA_W-1:0] a);
        logic [W1-1:0] sum;
        sum = {1'b0, a} + STEP_W;
        return (sum > MAX_W) ? MAX_A : sum[ALPHA_W-1:0];
    endfunction

    function automatic logic [ALPHA_W-1:0] sat_dn(input logic [ALPHA_W-1:0] a);
        logic [W1-1:0] diff;
        diff = {1'b0, a} - STEP_W;
        return diff[ALPHA_W] ? '0 : diff[ALPHA_W-1:0];
    endfunction

    assign both_held = held_up & held_dn;

    alpha_key_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_key_up (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n[KEY_UP]),
        .clr   (both_held),
        .press (press_up),
        .held  (held_up),
        .step  (step_up)
    );

    alpha_key_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_key_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n[KEY_DN]),
        .clr   (both_held),
        .press (press_dn),
        .held  (held_dn),
        .step  (step_dn)
    );

`ifdef ALPHA_RAMP_FADE_EN
    localparam int FADE_W = cnt_width(FADE_DIV, 1);

    logic              mode_q, mode_qd, mode_arm;
    logic              mode_press;
    logic              manual_act;
    logic              fade_dir;
    logic              fade_tick;
    logic [FADE_W-1:0] fade_cnt;

    assign mode_press = mode_arm & mode_qd & ~mode_q;
    assign manual_act = press_up | press_dn | step_up | step_dn;
    assign fade_tick  = fade_on & (fade_cnt == '0) & ~manual_act;
    assign do_up      = (step_up & ~step_dn) | (fade_tick & fade_dir);
    assign do_dn      = (step_dn & ~step_up) | (fade_tick & ~fade_dir);

    // Direction flips on the tick that lands on an endpoint, so each
    // endpoint is held for exactly one fade period like any other value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= 1'b1;
            mode_qd  <= 1'b1;
            mode_arm <= 1'b0;
            fade_on  <= 1'b0;
            fade_dir <= 1'b1;
            fade_cnt <= '0;
        end else begin
            mode_q   <= key_n[KEY_MODE];
            mode_qd  <= mode_q;
            mode_arm <= mode_arm | key_n[KEY_MODE];
            if (press_up || press_dn) begin
                fade_on <= 1'b0;
            end else if (mode_press) begin
                fade_on <= ~fade_on;
            end
            if (mode_press && !fade_on) begin
                fade_cnt <= FADE_W'(FADE_DIV - 1);
            end else if (fade_on) begin
                fade_cnt <= (fade_cnt == '0) ? FADE_W'(FADE_DIV - 1) : fade_cnt - FADE_W'(1);
            end
            if (fade_tick) begin
                if (fade_dir && alpha_nxt == MAX_A) begin
                    fade_dir <= 1'b0;
                end else if (!fade_dir && alpha_nxt == '0) begin
                    fade_dir <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_fade;

    assign unused_fade = key_n[KEY_MODE] | press_up | press_dn | (FADE_DIV == 0);
    assign fade_on     = 1'b0;
    assign do_up       = step_up & ~step_dn;
    assign do_dn       = step_dn & ~step_up;
`endif

    always_comb begin
        alpha_nxt = alpha_data;
        if (do_up) begin
            alpha_nxt = sat_up(alpha_data);
        end else if (do_dn) begin
            alpha_nxt = sat_dn(alpha_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alpha_data <= ALPHA_W'(ALPHA_INIT);
            alpha_inv  <= ALPHA_W'(ALPHA_MAX - ALPHA_INIT);
            alpha_vld  <= 1'b0;
        end else begin
            alpha_data <= alpha_nxt;
            alpha_inv  <= MAX_A - alpha_nxt;
            alpha_vld  <= (alpha_nxt != alpha_data);
        end
    end

endmodule

// File: tb/tb_alpha_ramp_ctrl.sv
// Directed bench for alpha_ramp_ctrl with short timer parameters; the fade
// section is selected by ALPHA_RAMP_FADE_EN to match the build under test.
module tb_alpha_ramp_ctrl;
    import alpha_ramp_pkg::*;

    localparam int ALPHA_W = 9;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic [2:0]         key_n = 3'b111;
    logic [ALPHA_W-1:0] alpha_data;
    logic [ALPHA_W-1:0] alpha_inv;
    logic               alpha_vld;
    logic               fade_on;

    int errors   = 0;
    int checks   = 0;
    int vld_seen = 0;

    always #5 clk = ~clk;

    alpha_ramp_ctrl #(
        .ALPHA_W    (ALPHA_W),
        .ALPHA_MAX  (256),
        .ALPHA_INIT (127),
        .STEP       (1),
        .REPEAT_DLY (10),
        .REPEAT_PER (4),
        .FADE_DIV   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .alpha_data (alpha_data),
        .alpha_inv  (alpha_inv),
        .alpha_vld  (alpha_vld),
        .fade_on    (fade_on)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and counting vld pulses.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (alpha_vld === 1'b1) vld_seen++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        vld_seen = 0;
    endtask

    initial begin
        // reset values
        rst_n = 1'b0;
        key_n = 3'b111;
        cyc(3);
        check("rst_alpha", 32'(alpha_data), 127);
        check("rst_inv",   32'(alpha_inv),  129);
        check("rst_vld",   32'(alpha_vld),  0);
        check("rst_fade",  32'(fade_on),    0);
        rst_n = 1'b1;
        cyc(2);
        vld_seen = 0;

        // single up press: two-cycle latency, one vld pulse
        key_n[KEY_UP] = 1'b0;
        cyc(1);
        check("up_lat1_alpha", 32'(alpha_data), 127);
        cyc(1);
        check("up_alpha", 32'(alpha_data), 128);
        check("up_inv",   32'(alpha_inv),  128);
        check("up_vld",   32'(alpha_vld),  1);
        cyc(1);
        check("up_vld_drop", 32'(alpha_vld), 0);
        key_n = 3'b111;
        cyc(12);
        check("up_tap_alpha", 32'(alpha_data), 128);
        check("up_tap_pulses", 32'(vld_seen), 1);

        // hold up 30 cycles: steps at +2, +12, then every 4
        do_reset();
        key_n[KEY_UP] = 1'b0;
        cyc(11);
        check("hold_pre_repeat", 32'(alpha_data), 128);
        cyc(1);
        check("hold_first_repeat", 32'(alpha_data), 129);
        cyc(3);
        check("hold_between", 32'(alpha_data), 129);
        cyc(1);
        check("hold_second_repeat", 32'(alpha_data), 130);
        cyc(14);
        check("hold_at_release", 32'(alpha_data), 133);
        key_n = 3'b111;
        cyc(10);
        check("hold_after_release", 32'(alpha_data), 133);
        check("hold_pulses", 32'(vld_seen), 6);

        // saturate at the top, then tap up at 256
        key_n[KEY_UP] = 1'b0;
        cyc(600);
        vld_seen = 0;
        cyc(20);
        check("sat_hi_alpha", 32'(alpha_data), 256);
        check("sat_hi_inv",   32'(alpha_inv),  0);
        check("sat_hi_repeat_pulses", 32'(vld_seen), 0);
        key_n = 3'b111;
        cyc(3);
        key_n[KEY_UP] = 1'b0;
        cyc(3);
        key_n = 3'b111;
        cyc(5);
        check("sat_hi_tap_alpha", 32'(alpha_data), 256);
        check("sat_hi_tap_pulses", 32'(vld_seen), 0);

        // ramp to the bottom, then tap down at 0
        key_n[KEY_DN] = 1'b0;
        cyc(1080);
        vld_seen = 0;
        cyc(20);
        check("sat_lo_alpha", 32'(alpha_data), 0);
        check("sat_lo_inv",   32'(alpha_inv),  256);
        check("sat_lo_repeat_pulses", 32'(vld_seen), 0);
        key_n = 3'b111;
        cyc(3);
        key_n[KEY_DN] = 1'b0;
        cyc(3);
        key_n = 3'b111;
        cyc(5);
        check("sat_lo_tap_alpha", 32'(alpha_data), 0);
        check("sat_lo_tap_pulses", 32'(vld_seen), 0);

        // up and down pressed together and held
        do_reset();
        key_n = 3'b100;
        cyc(30);
        check("both_alpha", 32'(alpha_data), 127);
        check("both_pulses", 32'(vld_seen), 0);
        key_n = 3'b111;
        cyc(3);
        key_n[KEY_UP] = 1'b0;
        cyc(2);
        check("both_then_up", 32'(alpha_data), 128);
        key_n = 3'b111;
        cyc(3);

        // reset during repeat with up held through reset release
        do_reset();
        key_n[KEY_UP] = 1'b0;
        cyc(14);
        check("rr_in_repeat", 32'(alpha_data), 129);
        rst_n = 1'b0;
        cyc(1);
        check("rr_reset_alpha", 32'(alpha_data), 127);
        check("rr_reset_vld",   32'(alpha_vld),  0);
        cyc(2);
        rst_n = 1'b1;
        vld_seen = 0;
        cyc(20);
        check("rr_held_alpha", 32'(alpha_data), 127);
        check("rr_held_pulses", 32'(vld_seen), 0);
        key_n = 3'b111;
        cyc(3);
        key_n[KEY_UP] = 1'b0;
        cyc(1);
        check("rr_repress_lat1", 32'(alpha_data), 127);
        cyc(1);
        check("rr_repress_alpha", 32'(alpha_data), 128);
        key_n = 3'b111;
        cyc(3);

        // ramp to 254 for the fade section
        do_reset();
        key_n[KEY_UP] = 1'b0;
        cyc(512);
        check("pre_fade_alpha", 32'(alpha_data), 254);
        key_n = 3'b111;
        cyc(2);
        check("pre_fade_settled", 32'(alpha_data), 254);
        vld_seen = 0;
        key_n[KEY_MODE] = 1'b0;
        cyc(2);
`ifdef ALPHA_RAMP_FADE_EN
        check("fade_on", 32'(fade_on), 1);
        check("fade_entry_alpha", 32'(alpha_data), 254);
        key_n = 3'b111;
        cyc(2);
        check("fade_t4", 32'(alpha_data), 254);
        cyc(1);
        check("fade_t5", 32'(alpha_data), 255);
        cyc(2);
        check("fade_t7", 32'(alpha_data), 255);
        cyc(1);
        check("fade_top", 32'(alpha_data), 256);
        check("fade_top_inv", 32'(alpha_inv), 0);
        cyc(3);
        check("fade_turn", 32'(alpha_data), 255);
        cyc(3);
        check("fade_down", 32'(alpha_data), 254);
        check("fade_pulses", 32'(vld_seen), 4);
        cyc(1);
        key_n[KEY_DN] = 1'b0;
        cyc(2);
        check("fade_exit_on", 32'(fade_on), 0);
        check("fade_exit_alpha", 32'(alpha_data), 253);
        check("fade_exit_inv", 32'(alpha_inv), 3);
        key_n = 3'b111;
        cyc(10);
        check("fade_exit_hold", 32'(alpha_data), 253);
        check("fade_exit_hold_on", 32'(fade_on), 0);
`else
        key_n = 3'b111;
        cyc(5);
        check("nofade_on", 32'(fade_on), 0);
        check("nofade_alpha", 32'(alpha_data), 254);
        check("nofade_pulses", 32'(vld_seen), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
